reg_sequencer: RTL and testbench

REG_SEQUENCER -- requirements
Module: reg_sequencer

---
 rtl/reg_sequencer.sv | 170 +++++++++++++++++
 tb/tb_reg_sequencer.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_sequencer.sv
// reg_sequencer: power-up/power-down sequencer for N_REG regulators with fault retry and lockout
// Ports:
//    clk        sole clock, rising edge
//    rst_n      asynchronous active-low reset
//    start      level: high requests power-up, low requests power-down
//    error_n    per-regulator ERROR flags, asynchronous, low = fault
//    clr_fault  single-cycle pulse, clears lockout
//    en         registered regulator enables
//    pgood      high only in ON
//    fault      high in BACKOFF and LOCKOUT
//    fault_idx  lowest faulting regulator index, latched
//    retry_cnt  retries consumed since the last clean start
//    state      OFF=0 RAMP=1 ON=2 SHDN=3 BACKOFF=4 LOCKOUT=5
module reg_sequencer #(
   parameter int N_REG         = 4,
   parameter int SETTLE_CYCLES = 1024,
   parameter int DEBOUNCE      = 8,
   parameter int RETRY_CYCLES  = 4096,
   parameter int MAX_RETRY     = 3
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [N_REG-1:0] error_n,
   input  logic             clr_fault,
   output logic [N_REG-1:0] en,
   output logic             pgood,
   output logic             fault,
   output logic [2:0]       fault_idx,
   output logic [1:0]       retry_cnt,
   output logic [2:0]       state
);
   typedef enum logic [2:0] {
      OFF     = 3'd0,
      RAMP    = 3'd1,
      ON      = 3'd2,
      SHDN    = 3'd3,
      BACKOFF = 3'd4,
      LOCKOUT = 3'd5
   } state_t;

   // counters run to zero, so loading N-1 gives N-cycle intervals
   localparam logic [15:0] S_LD = 16'(SETTLE_CYCLES - 1);
   localparam logic [15:0] R_LD = 16'(RETRY_CYCLES - 1);
   localparam logic [7:0]  DB   = 8'(DEBOUNCE);
   localparam logic [2:0]  LAST = 3'(N_REG - 1);
   localparam logic [1:0]  MAXR = 2'(MAX_RETRY);

   state_t           st;
   logic [15:0]      cnt;
   logic [2:0]       idx;
   logic             armed;
   logic [N_REG-1:0] s1, s2, flt, mask, hon;
   logic [2:0]       low;

   assign state = st;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         s1 <= '1;
         s2 <= '1;
      end else begin
         s1 <= error_n;
         s2 <= s1;
      end

   // saturating count of consecutive synchronized-low cycles per flag
   for (genvar i = 0; i < N_REG; i++) begin : g_db
      logic [7:0] dcnt;
      always_ff @(posedge clk or negedge rst_n)
         if (!rst_n) dcnt <= '0;
         else dcnt <= s2[i] ? '0 : (dcnt == DB ? dcnt : dcnt + 8'd1);
      assign flt[i] = dcnt == DB;
   end

   // the regulator currently ramping is ignored until its settle counter expires
   always_comb begin
      mask = (st == RAMP && cnt != '0) ? N_REG'(1) << idx : '0;
      hon  = flt & en & ~mask;
      low  = '0;
      for (int k = N_REG - 1; k >= 0; k--)
         if (hon[k]) low = 3'(k);
   end

   // en is always a contiguous run from bit 0, so shifting right drops the highest enabled regulator
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         st        <= OFF;
         en        <= '0;
         pgood     <= 1'b0;
         fault     <= 1'b0;
         fault_idx <= '0;
         retry_cnt <= '0;
         cnt       <= '0;
         idx       <= '0;
         armed     <= 1'b0;
      end else begin
         armed <= 1'b1;
         cnt   <= cnt != '0 ? cnt - 16'd1 : '0;
         if ((st == RAMP || st == ON || st == SHDN) && |hon) begin
            en        <= '0;
            pgood     <= 1'b0;
            fault_idx <= low;
            if (st == SHDN) st <= OFF;
            else if (retry_cnt < MAXR) begin
               st        <= BACKOFF;
               retry_cnt <= retry_cnt + 2'd1;
               cnt       <= R_LD;
               fault     <= 1'b1;
            end else begin
               st    <= LOCKOUT;
               fault <= 1'b1;
            end
         end else
            case (st)
               OFF:
                  if (start && armed) begin
                     st  <= RAMP;
                     idx <= '0;
                     en  <= N_REG'(1);
                     cnt <= S_LD;
                  end
               RAMP:
                  if (!start) begin
                     st  <= SHDN;
                     en  <= en >> 1;
                     cnt <= S_LD;
                  end else if (cnt == '0) begin
                     cnt <= S_LD;
                     if (idx == LAST) begin
                        st    <= ON;
                        pgood <= 1'b1;
                     end else begin
                        idx <= idx + 3'd1;
                        en  <= (en << 1) | N_REG'(1);
                     end
                  end
               ON:
                  if (!start) begin
                     st    <= SHDN;
                     pgood <= 1'b0;
                     en    <= en >> 1;
                     cnt   <= S_LD;
                  end else if (cnt == '0) retry_cnt <= '0;
               SHDN:
                  if (en == '0) st <= OFF;
                  else if (cnt == '0) begin
                     en  <= en >> 1;
                     cnt <= S_LD;
                  end
               BACKOFF:
                  if (cnt == '0) begin
                     fault <= 1'b0;
                     if (start) begin
                        st  <= RAMP;
                        idx <= '0;
                        en  <= N_REG'(1);
                        cnt <= S_LD;
                     end else st <= OFF;
                  end
               LOCKOUT:
                  if (clr_fault) begin
                     st        <= OFF;
                     retry_cnt <= '0;
                     fault     <= 1'b0;
                  end
               default: st <= OFF;
            endcase
      end
endmodule

// File: tb/tb_reg_sequencer.sv
// tb_reg_sequencer: directed and randomized checks of reg_sequencer against spec-derived expectations
module tb_reg_sequencer;
   localparam int NR = 4, ST = 16, DB = 4, RT = 32, MR = 2;

   logic          clk = 1'b0;
   logic          rst_n, start, clr_fault;
   logic [NR-1:0] error_n;
   logic [NR-1:0] en;
   logic          pgood, fault;
   logic [2:0]    fault_idx, state;
   logic [1:0]    retry_cnt;

   int n_cmp = 0, n_bad = 0;
   int cyc, b, len, r, backoffs, exp_retry;
   logic [2:0] prev;

   reg_sequencer #(
      .N_REG(NR), .SETTLE_CYCLES(ST), .DEBOUNCE(DB), .RETRY_CYCLES(RT), .MAX_RETRY(MR)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .error_n(error_n), .clr_fault(clr_fault),
      .en(en), .pgood(pgood), .fault(fault), .fault_idx(fault_idx), .retry_cnt(retry_cnt),
      .state(state)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_pgood(output int n);
      n = 0;
      while (pgood !== 1'b1 && n < 200) begin
         tick(1);
         n++;
      end
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; clr_fault = 1'b0; error_n = '1;
      tick(3);
      check("rst_state", 32'(state), 0);
      check("rst_en", 32'(en), 0);
      check("rst_pgood", 32'(pgood), 0);
      check("rst_fault", 32'(fault), 0);
      check("rst_fidx", 32'(fault_idx), 0);
      check("rst_retry", 32'(retry_cnt), 0);

      // start is held from deassertion; only the second edge may act on it
      rst_n = 1'b1; start = 1'b1;
      tick(1);
      check("start_edge1_en", 32'(en), 0);
      tick(1);
      check("start_edge2_en", 32'(en), 1);
      check("start_edge2_state", 32'(state), 1);

      // clean power-up: each 16-cycle step adds one enable
      cyc = 0;
      while (pgood !== 1'b1 && cyc < 200) begin
         tick(1);
         cyc++;
         if (cyc % ST == ST / 2 && cyc < NR * ST)
            check($sformatf("ramp_en_step%0d", cyc / ST), 32'(en), (1 << (cyc / ST + 1)) - 1);
      end
      check("pgood_latency_ok", 32'(cyc >= NR * ST - 1 && cyc <= NR * ST + 1), 1);
      check("on_state", 32'(state), 2);
      check("on_en", 32'(en), (1 << NR) - 1);

      // glitch shorter than debounce is ignored
      tick(20);
      b = int'($urandom_range(0, NR - 1));
      len = int'($urandom_range(1, DB - 1));
      error_n[b] = 1'b0;
      tick(len);
      error_n = '1;
      tick(10);
      check("glitch_state", 32'(state), 2);
      check("glitch_fault", 32'(fault), 0);
      check("glitch_en", 32'(en), (1 << NR) - 1);

      // debounced fault in ON
      b = int'($urandom_range(0, NR - 1));
      len = DB + int'($urandom_range(0, 2));
      exp_retry = 1;
      error_n[b] = 1'b0;
      tick(len);
      error_n = '1;
      tick(4);
      check("fault_en", 32'(en), 0);
      check("fault_flag", 32'(fault), 1);
      check("fault_idx", 32'(fault_idx), 32'(b));
      check("fault_retry", 32'(retry_cnt), 32'(exp_retry));
      check("fault_pgood", 32'(pgood), 0);
      check("fault_state", 32'(state), 4);

      // clr_fault outside lockout does nothing
      clr_fault = 1'b1;
      tick(1);
      clr_fault = 1'b0;
      check("clr_backoff_state", 32'(state), 4);
      check("clr_backoff_retry", 32'(retry_cnt), 32'(exp_retry));

      // back-off expiry with start low returns to OFF
      start = 1'b0;
      tick(RT + 8);
      check("backoff_off_state", 32'(state), 0);
      check("backoff_off_fault", 32'(fault), 0);
      check("backoff_off_retry", 32'(retry_cnt), 32'(exp_retry));
      check("backoff_off_fidx_hold", 32'(fault_idx), 32'(b));

      // clean power-up clears retry count after a settle period in ON
      start = 1'b1;
      wait_pgood(cyc);
      check("pu2_pgood", 32'(pgood), 1);
      tick(ST + 4);
      exp_retry = 0;
      check("pu2_retry_clear", 32'(retry_cnt), 32'(exp_retry));

      // shutdown: reverse order, first bit on entry edge
      start = 1'b0;
      tick(1);
      check("shdn_entry_en", 32'(en), 7);
      check("shdn_entry_pgood", 32'(pgood), 0);
      check("shdn_entry_state", 32'(state), 3);
      tick(ST / 2);
      for (int k = 0; k < NR; k++) begin
         check($sformatf("shdn_en_step%0d", k), 32'(en), (1 << (NR - 1 - k)) - 1);
         tick(ST);
      end
      check("shdn_done_state", 32'(state), 0);

      // settle mask: error on regulator 0 during its own ramp step is ignored
      start = 1'b1;
      error_n[0] = 1'b0;
      len = int'($urandom_range(4, 10));
      tick(len);
      error_n = '1;
      wait_pgood(cyc);
      check("mask_pgood", 32'(pgood), 1);
      check("mask_fault", 32'(fault), 0);
      check("mask_en", 32'(en), (1 << NR) - 1);

      // persistent fault exhausts retries
      r = int'($urandom_range(0, NR - 1));
      error_n[r] = 1'b0;
      backoffs = 0;
      prev = state;
      cyc = 0;
      while (state !== 3'd5 && cyc < 3000) begin
         tick(1);
         cyc++;
         if (state === 3'd4 && prev !== 3'd4) backoffs++;
         prev = state;
      end
      check("lock_state", 32'(state), 5);
      check("lock_backoffs", 32'(backoffs), MR);
      check("lock_retry", 32'(retry_cnt), MR);
      check("lock_fault", 32'(fault), 1);
      check("lock_fidx", 32'(fault_idx), 32'(r));
      check("lock_en", 32'(en), 0);
      tick(40);
      check("lock_ignores_start", 32'(state), 5);

      error_n = '1;
      start = 1'b0;
      tick(2);
      clr_fault = 1'b1;
      tick(1);
      clr_fault = 1'b0;
      check("clr_state", 32'(state), 0);
      check("clr_fault", 32'(fault), 0);
      check("clr_retry", 32'(retry_cnt), 0);
      check("clr_fidx_hold", 32'(fault_idx), 32'(r));

      // asynchronous reset while ON
      start = 1'b1;
      tick(2);
      wait_pgood(cyc);
      check("pu3_pgood", 32'(pgood), 1);
      rst_n = 1'b0;
      #1;
      check("arst_en", 32'(en), 0);
      check("arst_pgood", 32'(pgood), 0);
      check("arst_state", 32'(state), 0);
      check("arst_fidx", 32'(fault_idx), 0);
      check("arst_retry", 32'(retry_cnt), 0);
      tick(2);
      rst_n = 1'b1;
      tick(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
